tile_config_receiver: RTL
=========================

// Module: tile_config_receiver
//
// PURPOSE
//   Responder end of the tile configuration bus: the bus master drives
//   config_addr/config_data; this block decodes and stores them.
//   - Decodes tile/feature/register fields and holds writes in shadow registers.
//   - Publishes the shadows to the tile fabric atomically on a commit command.
//   - Answers readback requests with an OR-able response.
//   One instance sits per feature per tile. Its config_out drives that
//   feature's mux/opcode selects.
//
// PARAMETERS
//   TILE_ID     16'h0000  tile identifier matched against config_addr[15:0]
//   FEATURE_ID  8'h00     feature identifier matched against config_addr[23:16]
//   NUM_REGS    4         number of 32-bit config registers (1..16)
//
// PORTS
//   clk          in   1            clock
//   reset        in   1            asynchronous, active-low reset
//   config_en    in   1            addr/data/read valid this cycle
//   config_read  in   1            1 = read request, 0 = write request (qualified by config_en)
//   config_addr  in   32           [31:24] reg, [23:16] feature, [15:0] tile
//   config_data  in   32           write data
//   read_data    out  32           readback data; 0 when not responding
//   read_valid   out  1            one-cycle strobe: read_data valid
//   config_out   out  NUM_REGS*32  active registers, reg i at [32*i+31:32*i]
//   commit_pulse out  1            one-cycle strobe: active registers just updated
//   err_count    out  8            saturating count of bad-register accesses
//
// BEHAVIOUR
// - Reset (async assert, low): all outputs, all shadow/active registers,
//   the dirty flag, err_count and the input stage are cleared to 0.
//   In-flight requests are discarded. Deassertion is synchronised by the
//   integrator; this block samples normally from the first edge after release.
// - Stage 1 (edge N): register en, read, addr and data.
//   Decode from the registered copy:
//     hit  = tile==TILE_ID && feature==FEATURE_ID
//     cmd  = reg==8'hFF
//     good = reg<NUM_REGS
// - Stage 2 (edge N+1) actions, by registered request type:
//   - Write, hit & good: shadow[reg] <= data; dirty <= 1.
//   - Write, hit & cmd (commit): active[i] <= shadow[i] for all i;
//     dirty <= 0; commit_pulse=1 for one cycle. config_out changes only here.
//   - Read, hit & good: read_data <= shadow[reg]; read_valid=1 for one cycle.
//   - Read, hit & cmd: read_data <= {31'b0, dirty}; read_valid=1.
//   - Hit & !good & !cmd (read or write): no register change;
//     err_count += 1, saturating at 8'hFF; a read still returns
//     read_valid=1 with read_data=0.
//   - Miss, or en=0: no state change; read_valid=0 and read_data=0,
//     so responses from many instances can be ORed.
// - Latency: request presented before edge N -> effect or response after
//   edge N+1 (2 cycles). Fully pipelined; one request per cycle.
// - Back-to-back hazards need no stall: a write at N followed by a read or
//   commit of the same reg at N+1 observes the new value. Stage 2 of the
//   write completes at the same edge where stage 1 of the read captures.
// - Writes are never visible on config_out until a commit. A commit with
//   dirty=0 still pulses and re-copies (idempotent).
// - A master holding config_en high with constant addr/data repeats the
//   write each cycle. This is harmless and the dirty flag stays 1.
// - read_data/read_valid/commit_pulse are registered outputs; they are low
//   in every cycle without a corresponding stage-2 event.
//
// TESTING
//   1. Write 0xDEADBEEF to reg1 of matching tile/feature -> read reg1
//      returns 0xDEADBEEF two cycles later; config_out unchanged (0);
//      read of reg FF returns 1.
//   2. Commit (reg FF write) -> commit_pulse high exactly one cycle;
//      config_out[63:32]=0xDEADBEEF; dirty read now returns 0.
//   3. Write with tile=TILE_ID+1, then with feature mismatch ->
//      no shadow change, read_valid never asserted, read_data stays 0.
//   4. Back-to-back: write reg0=0x12345678 at N, read reg0 at N+1,
//      commit at N+2 -> read returns 0x12345678; config_out[31:0]=0x12345678.
//   5. 300 writes to reg NUM_REGS (invalid) -> err_count saturates at 0xFF;
//      registers unchanged; a read of the invalid reg gives read_valid=1, data 0.
//   6. Assert reset mid-stream (write in stage 1, committed values live) ->
//      all outputs 0 immediately; the in-flight write is never applied after release.

Source files
------------

// File: rtl/tile_config_receiver.sv
// Configuration-bus responder for one feature of one tile: decodes writes into shadow
// registers, publishes them on commit, and answers OR-able readback requests.
module tile_config_receiver #(
    parameter logic [15:0] TILE_ID    = 16'h0000,
    parameter logic [7:0]  FEATURE_ID = 8'h00,
    parameter int unsigned NUM_REGS   = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_config_en,
    input  logic                     i_config_read,
    input  logic [31:0]              i_config_addr,
    input  logic [31:0]              i_config_data,
    output logic [31:0]              o_read_data,
    output logic                     o_read_valid,
    output logic [NUM_REGS*32-1:0]   o_config_out,
    output logic                     o_commit_pulse,
    output logic [7:0]               o_err_count
);

    logic                   r_en;
    logic                   r_read;
    logic [31:0]            r_addr;
    logic [31:0]            r_data;
    logic [NUM_REGS*32-1:0] r_shadow;
    logic [NUM_REGS*32-1:0] r_active;
    logic                   r_dirty;
    logic [31:0]            r_read_data;
    logic                   r_read_valid;
    logic                   r_commit;
    logic [7:0]             r_err_count;

    logic [7:0]             w_reg;
    logic                   w_hit;
    logic                   w_cmd;
    logic                   w_good;
    logic [31:0]            w_shadow_rd;

    assign w_reg  = r_addr[31:24];
    assign w_hit  = (r_addr[15:0] == TILE_ID) && (r_addr[23:16] == FEATURE_ID);
    assign w_cmd  = (w_reg == 8'hFF);
    assign w_good = (32'(w_reg) < NUM_REGS);

    always_comb begin
        w_shadow_rd = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (w_reg == 8'(i)) begin
                w_shadow_rd = r_shadow[32*i +: 32];
            end
        end
    end

    // Stage 1 captures the request; stage 2 acts on the captured copy at the same edge,
    // so a write followed immediately by a read of the same register sees the new value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_en         <= 1'b0;
            r_read       <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_shadow     <= '0;
            r_active     <= '0;
            r_dirty      <= 1'b0;
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_commit     <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_en         <= i_config_en;
            r_read       <= i_config_read;
            r_addr       <= i_config_addr;
            r_data       <= i_config_data;
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
            r_commit     <= 1'b0;
            if (r_en && w_hit) begin
                if (r_read) begin
                    r_read_valid <= 1'b1;
                    if (w_good) begin
                        r_read_data <= w_shadow_rd;
                    end else if (w_cmd) begin
                        r_read_data <= {31'b0, r_dirty};
                    end
                end else if (w_good) begin
                    for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        if (w_reg == 8'(i)) begin
                            r_shadow[32*i +: 32] <= r_data;
                        end
                    end
                    r_dirty <= 1'b1;
                end else if (w_cmd) begin
                    r_active <= r_shadow;
                    r_dirty  <= 1'b0;
                    r_commit <= 1'b1;
                end
                if (!w_good && !w_cmd && (r_err_count != 8'hFF)) begin
                    r_err_count <= r_err_count + 8'd1;
                end
            end
        end
    end

    assign o_read_data    = r_read_data;
    assign o_read_valid   = r_read_valid;
    assign o_config_out   = r_active;
    assign o_commit_pulse = r_commit;
    assign o_err_count    = r_err_count;

endmodule
